// File: rtl/moore_seq.sv
// moore_seq: parametrised one-hot Moore sequencer with programmable dwell,
// runtime direction, wrap/stop/bounce modes and synchronous index load.
module moore_seq #(
    parameter int unsigned NUM_STATES = 4,
    parameter int unsigned DWELL_W    = 8,
    localparam int unsigned IDX_W     = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [NUM_STATES-1:0] out,
    output logic [IDX_W-1:0]      idx,
    output logic                  wrap,
    output logic                  at_first,
    output logic                  at_last
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STATES - 1);
    localparam logic [1:0]       MODE_STOP   = 2'b01;
    localparam logic [1:0]       MODE_BOUNCE = 2'b10;

    logic [IDX_W-1:0]   idx_r,  idx_n;
    logic [DWELL_W-1:0] cnt_r,  cnt_n;
    logic               bdir_r, bdir_n;
    logic               wrap_r, wrap_n;
    logic               eff_dir;
    logic               at_end;

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r  <= '0;
            cnt_r  <= '0;
            bdir_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            idx_r  <= idx_n;
            cnt_r  <= cnt_n;
            bdir_r <= bdir_n;
            wrap_r <= wrap_n;
        end
    end

    // Next-state logic: load beats enable, enable beats hold
    always_comb begin
        idx_n   = idx_r;
        cnt_n   = cnt_r;
        bdir_n  = bdir_r;
        wrap_n  = 1'b0;
        eff_dir = (mode == MODE_BOUNCE) ? bdir_r : dir;
        at_end  = eff_dir ? (idx_r == '0) : (idx_r == LAST_IDX);

        if (load) begin
            idx_n  = (load_idx > LAST_IDX) ? LAST_IDX : load_idx;
            cnt_n  = '0;
            bdir_n = dir;
        end else if (en) begin
            if (cnt_r < dwell) begin
                cnt_n = cnt_r + DWELL_W'(1);
            end else begin
                // Dwell expired: take one step in the effective direction
                cnt_n = '0;
                if (!at_end) begin
                    idx_n = eff_dir ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
                end else if (mode == MODE_BOUNCE) begin
                    idx_n  = eff_dir ? (idx_r + IDX_W'(1)) : (idx_r - IDX_W'(1));
                    bdir_n = ~bdir_r;
                    wrap_n = 1'b1;
                end else if (mode == MODE_STOP) begin
                    idx_n = idx_r;
                end else begin
                    idx_n  = eff_dir ? LAST_IDX : '0;
                    wrap_n = 1'b1;
                end
            end
        end
    end

    // Moore output decode from the index register only
    always_comb begin
        out      = NUM_STATES'(1) << idx_r;
        idx      = idx_r;
        wrap     = wrap_r;
        at_first = (idx_r == '0);
        at_last  = (idx_r == LAST_IDX);
    end

endmodule

// File: tb/tb_moore_seq.sv
// Directed bench for moore_seq: a 4-state and a 5-state instance share stimulus;
// expected states are queued as each step is driven and checked after the edge.
module tb_moore_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_idx;
    logic [7:0] dwell;

    logic [3:0] out4;
    logic [1:0] idx4;
    logic       wrap4, first4, last4;
    logic [4:0] out5;
    logic [2:0] idx5;
    logic       wrap5, first5, last5;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string tag;
        int    dut;
        int    idx;
        logic  wrap;
    } exp_t;

    exp_t exp_q[$];

    moore_seq #(.NUM_STATES(4), .DWELL_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_idx(load_idx[1:0]), .dwell(dwell), .out(out4), .idx(idx4),
        .wrap(wrap4), .at_first(first4), .at_last(last4)
    );

    moore_seq #(.NUM_STATES(5), .DWELL_W(8)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_idx(load_idx), .dwell(dwell), .out(out5), .idx(idx5),
        .wrap(wrap5), .at_first(first5), .at_last(last5)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input int act, input int req);
        n_cmp++;
        assert (act === req) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, act, req);
        end
    endtask

    task automatic expect_state(input string tag, input int dut, input int idx, input logic w);
        exp_t e;
        e.tag = tag; e.dut = dut; e.idx = idx; e.wrap = w;
        exp_q.push_back(e);
    endtask

    // Pop every queued expectation and compare it against the selected instance
    task automatic check_pending();
        exp_t e;
        int   a_idx, a_out, a_first, a_last, a_wrap, r_out;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.dut == 4) begin
                a_idx = int'(idx4); a_out = int'(out4); a_wrap = int'(wrap4);
                a_first = int'(first4); a_last = int'(last4);
            end else begin
                a_idx = int'(idx5); a_out = int'(out5); a_wrap = int'(wrap5);
                a_first = int'(first5); a_last = int'(last5);
            end
            r_out = 1 << e.idx;
            cmp({e.tag, ".idx"},      a_idx,   e.idx);
            cmp({e.tag, ".out"},      a_out,   r_out);
            cmp({e.tag, ".wrap"},     a_wrap,  int'(e.wrap));
            cmp({e.tag, ".at_first"}, a_first, (e.idx == 0) ? 1 : 0);
            cmp({e.tag, ".at_last"},  a_last,  (e.idx == e.dut - 1) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_pending();
    endtask

    // Assert reset mid-cycle, check async clear, release after one edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        expect_state({tag, "_rst4"}, 4, 0, 1'b0);
        expect_state({tag, "_rst5"}, 5, 0, 1'b0);
        check_pending();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int seq_a[5];
        int wrp_a[5];
        int seq_d[10];
        int wrp_d[10];

        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0;
        load_idx = 3'd0; dwell = 8'd0;
        @(posedge clk);
        #1;
        do_reset("init");

        // Wrap mode, up, dwell 0 on the 4-state instance
        seq_a = '{1, 2, 3, 0, 1};
        wrp_a = '{0, 0, 0, 1, 0};
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_state($sformatf("wrap4_s%0d", i), 4, seq_a[i], wrp_a[i] != 0);
            tick();
        end

        // Dwell 2 with enable pattern 1,1,0,1: step only on third enabled edge
        en = 1'b0;
        do_reset("dwell");
        dwell = 8'd2;
        en = 1'b1; expect_state("dwell_e1", 5, 0, 1'b0); tick();
        en = 1'b1; expect_state("dwell_e2", 5, 0, 1'b0); tick();
        en = 1'b0; expect_state("dwell_hold", 5, 0, 1'b0); tick();
        en = 1'b1; expect_state("dwell_e3", 5, 1, 1'b0); tick();

        // Stop mode, down, from idx 2: reach 0 and stay there without wrap
        dwell = 8'd0; mode = 2'b01; dir = 1'b1; en = 1'b1;
        load = 1'b1; load_idx = 3'd2;
        expect_state("stop_load", 5, 2, 1'b0); tick();
        load = 1'b0;
        expect_state("stop_s1", 5, 1, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            expect_state($sformatf("stop_hold%0d", i), 5, 0, 1'b0);
            tick();
        end

        // Bounce on 5 states; dir held at 1 must not affect bounce direction
        en = 1'b0;
        do_reset("bounce");
        mode = 2'b10; dir = 1'b1; dwell = 8'd0; en = 1'b1;
        seq_d = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        wrp_d = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            expect_state($sformatf("bounce_s%0d", i), 5, seq_d[i], wrp_d[i] != 0);
            tick();
        end

        // Out-of-range load at dwell expiry clamps, clears count, no step
        en = 1'b0;
        do_reset("load");
        mode = 2'b00; dir = 1'b0; dwell = 8'd1; en = 1'b1;
        expect_state("load_pre", 5, 0, 1'b0); tick();
        load = 1'b1; load_idx = 3'd7; dir = 1'b1;
        expect_state("load_clamp", 5, 4, 1'b0); tick();
        load = 1'b0;
        expect_state("load_dwell", 5, 4, 1'b0); tick();
        expect_state("load_step", 5, 3, 1'b0); tick();

        // Async reset mid-dwell (dwell 5, cnt 3, idx 2)
        mode = 2'b00; dir = 1'b0; dwell = 8'd5; en = 1'b1;
        load = 1'b1; load_idx = 3'd2;
        expect_state("ar_load", 5, 2, 1'b0); tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_state($sformatf("ar_cnt%0d", i), 5, 2, 1'b0);
            tick();
        end
        do_reset("ar");
        for (int i = 0; i < 5; i++) begin
            expect_state($sformatf("ar_dwell%0d", i), 5, 0, 1'b0);
            tick();
        end
        expect_state("ar_step", 5, 1, 1'b0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
